// File: rtl/win_event_gen.sv
// Win-event producer: counts the bird's column advances, strobes pin/farMost on a far-column win,
// and clears or locks the playfield from the counter's out line. Optional: ACK_RETRY_EN (strobe re-send).
module win_event_gen #(
  parameter int NCOLS        = 8,
  parameter int CLEAR_CYCLES = 4
`ifdef ACK_RETRY_EN
  ,parameter int ACK_TIMEOUT = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     crash,
  input  logic                     win_out,
  output logic                     pin,
  output logic                     farMost,
  output logic                     field_reset,
  output logic                     locked,
  output logic [$clog2(NCOLS)-1:0] column
);

  localparam int CW = $clog2(NCOLS);
  localparam int KW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NCOLS - 1);
  localparam logic [KW-1:0] CLR_LAST = KW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SEND     = 3'd1,
    WAIT_ACK = 3'd2,
    CLEAR    = 3'd3,
    LOCK     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] column_q, column_d;
  logic [KW-1:0] clr_q, clr_d;
  logic          to_fire;

`ifdef ACK_RETRY_EN
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] to_q, to_d;

  // Counts unacknowledged WAIT_ACK cycles; every SEND restarts the window.
  always_comb begin
    to_d = to_q;
    if (state_q == SEND) to_d = '0;
    else if (state_q == WAIT_ACK && !win_out) to_d = to_q + TW'(1);
  end

  assign to_fire = (state_q == WAIT_ACK) && !win_out && (to_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) to_q <= '0;
    else       to_q <= to_d;
  end
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    column_d = column_q;
    clr_d    = clr_q;
    case (state_q)
      RUN: begin
        if (crash) begin
          state_d  = CLEAR;
          column_d = '0;
        end else if (tick) begin
          if (column_q == COL_LAST) state_d  = SEND;
          else                      column_d = column_q + CW'(1);
        end
      end
      SEND: begin
        if (win_out) begin
          state_d  = CLEAR;
          column_d = '0;
        end else begin
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (win_out) begin
          state_d  = CLEAR;
          column_d = '0;
        end else if (to_fire) begin
          state_d  = SEND;
        end
      end
      CLEAR: begin
        // out still high after the strobe dropped means the counter is saturated.
        if (clr_q == CLR_LAST) begin
          clr_d   = '0;
          state_d = win_out ? LOCK : RUN;
        end else begin
          clr_d   = clr_q + KW'(1);
        end
      end
      LOCK:    state_d = LOCK;
      default: begin
        state_d  = RUN;
        column_d = '0;
        clr_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      column_q <= '0;
      clr_q    <= '0;
    end else begin
      state_q  <= state_d;
      column_q <= column_d;
      clr_q    <= clr_d;
    end
  end

  assign pin         = (state_q == SEND);
  assign farMost     = pin;
  assign field_reset = (state_q == CLEAR) || (state_q == LOCK);
  assign locked      = (state_q == LOCK);
  assign column      = column_q;

endmodule

// File: tb/tb_win_event_gen.sv
// Scoreboard bench for win_event_gen: a cycle model pushes expected outputs, sampled DUT outputs pop them.
`timescale 1ns/1ps
module tb_win_event_gen;
  localparam int NCOLS = 8;
  localparam int CC    = 4;
  localparam int CW    = $clog2(NCOLS);
`ifdef ACK_RETRY_EN
  localparam int ATO   = 16;
`endif

  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, crash = 1'b0, win_out = 1'b0;
  logic pin, farMost, field_reset, locked;
  logic [CW-1:0] column;

  win_event_gen #(.NCOLS(NCOLS), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .tick(tick), .crash(crash), .win_out(win_out),
    .pin(pin), .farMost(farMost), .field_reset(field_reset), .locked(locked), .column(column)
  );

  always #5 clk = ~clk;

  typedef enum int {M_RUN, M_SEND, M_WAIT, M_CLEAR, M_LOCK} mst_t;
  typedef struct packed {
    logic          pin;
    logic          far;
    logic          fr;
    logic          lk;
    logic [CW-1:0] col;
  } obs_t;

  mst_t m_st = M_RUN;
  int   m_col = 0, m_clr = 0, m_to = 0;
  obs_t exp_q[$];
  int   pin_at[$];
  int   n_chk = 0, n_fail = 0, cnum = 0, pin_seen = 0, fr_seen = 0;
  logic prev_pin = 1'b0;
  logic ack_auto = 1'b1, wo_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cnum);
    end
  endtask

  task automatic model_step(input logic t, input logic c, input logic r, input logic w);
    if (r) begin
      m_st = M_RUN; m_col = 0; m_clr = 0; m_to = 0;
    end else begin
      case (m_st)
        M_RUN: begin
          if (c) begin m_st = M_CLEAR; m_col = 0; end
          else if (t) begin
            if (m_col == NCOLS - 1) m_st = M_SEND;
            else m_col++;
          end
        end
        M_SEND: begin
          m_to = 0;
          if (w) begin m_st = M_CLEAR; m_col = 0; end
          else m_st = M_WAIT;
        end
        M_WAIT: begin
          if (w) begin m_st = M_CLEAR; m_col = 0; end
`ifdef ACK_RETRY_EN
          else begin
            m_to++;
            if (m_to == ATO) m_st = M_SEND;
          end
`endif
        end
        M_CLEAR: begin
          m_clr++;
          if (m_clr == CC) begin
            m_clr = 0;
            m_st  = w ? M_LOCK : M_RUN;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input logic t, input logic c, input logic r, input logic wo, input string tag);
    logic w;
    obs_t e, g;
    w = (ack_auto && m_st == M_SEND) || wo_force || wo;
    tick = t; crash = c; reset = r; win_out = w;
    @(posedge clk);
    model_step(t, c, r, w);
    e.pin = (m_st == M_SEND);
    e.far = e.pin;
    e.fr  = (m_st == M_CLEAR) || (m_st == M_LOCK);
    e.lk  = (m_st == M_LOCK);
    e.col = CW'(m_col);
    exp_q.push_back(e);
    #1;
    cnum++;
    g = {pin, farMost, field_reset, locked, column};
    chk(tag, 32'(g), 32'(exp_q.pop_front()));
    chk("pin_b2b", 32'(pin & prev_pin), 32'(0));
    prev_pin = pin;
    if (pin === 1'b1) begin pin_seen++; pin_at.push_back(cnum); end
    if (field_reset === 1'b1) fr_seen++;
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic clr_stats();
    pin_seen = 0; fr_seen = 0; pin_at.delete();
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "reset");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "reset");
    chk("rst_outs", 32'({pin, farMost, field_reset, locked}), 32'(0));
    chk("rst_col", 32'(column), 32'(0));

    // Normal win with win_out tied to pin
    clr_stats();
    ticks(7, "win_tick");
    chk("col_far", 32'(column), 32'(NCOLS - 1));
    ticks(1, "win_tick");
    chk("pin_after_tick", 32'(pin), 32'(1));
    idle(6, "win_clear");
    chk("win_pins", 32'(pin_seen), 32'(1));
    chk("win_fr_len", 32'(fr_seen), 32'(CC));
    chk("win_col0", 32'(column), 32'(0));

    // Crash mid-field, then crash together with the winning tick
    clr_stats();
    ticks(3, "crash_tick");
    chk("col3", 32'(column), 32'(3));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "crash");
    idle(6, "crash_clear");
    chk("crash_pins", 32'(pin_seen), 32'(0));
    chk("crash_fr_len", 32'(fr_seen), 32'(CC));
    clr_stats();
    ticks(7, "crash2_tick");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "crash_tick7");
    idle(6, "crash2_clear");
    chk("crash2_pins", 32'(pin_seen), 32'(0));
    chk("crash2_fr_len", 32'(fr_seen), 32'(CC));
    chk("crash2_col0", 32'(column), 32'(0));

    // Saturation: wins 2..6 normal, win 7 with win_out held high afterwards
    for (int k = 0; k < 5; k++) begin
      ticks(NCOLS, "sat_tick");
      idle(6, "sat_clear");
    end
    ticks(NCOLS, "sat_tick7");
    wo_force = 1'b1;
    idle(6, "sat_lock");
    chk("sat_locked", 32'(locked), 32'(1));
    chk("sat_fr", 32'(field_reset), 32'(1));
    ticks(5, "lock_tick");
    chk("lock_col", 32'(column), 32'(0));
    chk("lock_held", 32'({locked, field_reset}), 32'(3));
    wo_force = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "lock_reset");
    chk("unlock_outs", 32'({pin, farMost, field_reset, locked}), 32'(0));

    // Delayed ack: win_out rises 5 cycles after the strobe
    ack_auto = 1'b0;
    clr_stats();
    ticks(NCOLS, "dly_tick");
    idle(5, "dly_wait");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, "dly_ack");
    chk("dly_clear_start", 32'(field_reset), 32'(1));
    idle(4, "dly_clear");
    chk("dly_pins", 32'(pin_seen), 32'(1));
    chk("dly_fr_len", 32'(fr_seen), 32'(CC));

`ifdef ACK_RETRY_EN
    // Retry: no ack until the third strobe
    ticks(NCOLS, "rty_tick");
    clr_stats();
    pin_at.push_back(cnum);
    pin_seen = 1;
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b0, 1'b0, (m_st == M_SEND) && (pin_at.size() == 3), "retry");
    chk("rty_pulses", 32'(pin_at.size()), 32'(3));
    if (pin_at.size() == 3) begin
      chk("rty_gap1", 32'(pin_at[1] - pin_at[0]), 32'(ATO + 1));
      chk("rty_gap2", 32'(pin_at[2] - pin_at[1]), 32'(ATO + 1));
    end
    chk("rty_fr_len", 32'(fr_seen), 32'(CC));
    chk("rty_col0", 32'(column), 32'(0));
`endif
    ack_auto = 1'b1;

    // Reset in the middle of CLEAR
    ticks(NCOLS, "rc_tick");
    idle(2, "rc_clear");
    chk("rc_in_clear", 32'(field_reset), 32'(1));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "rc_reset");
    chk("rc_outs", 32'({pin, farMost, field_reset, locked, column}), 32'(0));
    ticks(1, "rc_tick1");
    chk("rc_col1", 32'(column), 32'(1));

    // Reset in the middle of WAIT_ACK
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "rw_pre");
    ack_auto = 1'b0;
    ticks(NCOLS, "rw_tick");
    idle(3, "rw_wait");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "rw_reset");
    chk("rw_outs", 32'({pin, farMost, field_reset, locked, column}), 32'(0));
    ticks(1, "rw_tick1");
    chk("rw_col1", 32'(column), 32'(1));
    ack_auto = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
